// File: rtl/cva6_sb_id_ring_pkg.sv
// Shared types, limits and the ack-prefix helper for the scoreboard ID ring.
package cva6_sb_id_ring_pkg;

  localparam int MAX_COMMIT_PORTS = 4;
  localparam int RCNT_W           = $clog2(MAX_COMMIT_PORTS + 1);
  localparam int DEF_NR_ENTRIES   = 8;
  localparam int DEF_ID_W         = $clog2(DEF_NR_ENTRIES);

  // Templates for the default configuration; the ring resizes its own copies.
  typedef logic [DEF_ID_W-1:0] sb_id_t;
  typedef logic [DEF_ID_W:0]   sb_ptr_t;

  // Length of the run of ones starting at bit 0.
  function automatic logic [RCNT_W-1:0] prefix_len(input logic [MAX_COMMIT_PORTS-1:0] v);
    logic [RCNT_W-1:0] n;
    logic              run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_COMMIT_PORTS; i++) begin
      run = run & v[i];
      n   = n + RCNT_W'(run);
    end
    return n;
  endfunction

endpackage

// File: rtl/cva6_sb_id_ring_if.sv
// Issue / writeback / commit bundle of the scoreboard ID ring.
interface cva6_sb_id_ring_if #(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_COMMIT_PORTS = 2
);
  localparam int ID_W  = $clog2(NR_ENTRIES);
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);

  logic                            flush_i;
  logic                            issue_req_i;
  logic                            issue_gnt_o;
  logic [ID_W-1:0]                 issue_id_o;
  logic                            wb_valid_i;
  logic [ID_W-1:0]                 wb_id_i;
  logic [NR_COMMIT_PORTS-1:0]      commit_valid_o;
  logic [NR_COMMIT_PORTS*ID_W-1:0] commit_id_o;
  logic [NR_COMMIT_PORTS-1:0]      commit_ack_i;
  logic [CNT_W-1:0]                usage_o;
  logic                            empty_o;
  logic                            full_o;
  logic [31:0]                     perf_stall_cnt_o;

  modport slave (
    input  flush_i, issue_req_i, wb_valid_i, wb_id_i, commit_ack_i,
    output issue_gnt_o, issue_id_o, commit_valid_o, commit_id_o,
           usage_o, empty_o, full_o, perf_stall_cnt_o
  );

  modport master (
    output flush_i, issue_req_i, wb_valid_i, wb_id_i, commit_ack_i,
    input  issue_gnt_o, issue_id_o, commit_valid_o, commit_id_o,
           usage_o, empty_o, full_o, perf_stall_cnt_o
  );
endinterface

// File: rtl/cva6_sb_commit_sel.sv
// Combinational commit window: in-order valid&done run from head, and retire count from acks.
module cva6_sb_commit_sel
  import cva6_sb_id_ring_pkg::*;
#(
  parameter int  NR_ENTRIES      = 8,
  parameter int  NR_COMMIT_PORTS = 2,
  localparam int ID_W            = $clog2(NR_ENTRIES)
) (
  input  logic [NR_ENTRIES-1:0]           valid,
  input  logic [NR_ENTRIES-1:0]           done,
  input  logic [ID_W-1:0]                 head,
  input  logic [NR_COMMIT_PORTS-1:0]      ack,
  output logic [NR_COMMIT_PORTS-1:0]      commit_valid,
  output logic [NR_COMMIT_PORTS*ID_W-1:0] commit_id,
  output logic [RCNT_W-1:0]               retire_cnt
);

  logic [ID_W-1:0]             idx;
  logic                        run;
  logic [MAX_COMMIT_PORTS-1:0] take;

  // Port k is live only if every older port is live; idle ports show ID 0.
  always_comb begin
    idx          = '0;
    run          = 1'b1;
    commit_valid = '0;
    commit_id    = '0;
    take         = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      idx             = head + ID_W'(k);
      run             = run & valid[idx] & done[idx];
      commit_valid[k] = run;
      commit_id[k*ID_W +: ID_W] = run ? idx : '0;
    end
    take[NR_COMMIT_PORTS-1:0] = ack & commit_valid;
    retire_cnt = prefix_len(take);
  end

endmodule

// File: rtl/cva6_sb_id_ring.sv
// In-order scoreboard transaction-ID ring (issue, writeback, multi-port commit).
// Optional stall counter enabled by defining CVA6_SB_ID_RING_PERF_EN.
module cva6_sb_id_ring
  import cva6_sb_id_ring_pkg::*;
#(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cva6_sb_id_ring_if.slave bus
);

  localparam int ID_W  = $clog2(NR_ENTRIES);
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);
  localparam int PTR_W = ID_W + 1;

  logic [PTR_W-1:0]           head, tail, head_next, tail_next, usage_ptr;
  logic [NR_ENTRIES-1:0]      valid, done, valid_next, done_next;
  logic                       full, empty, issue_fire;
  logic [NR_COMMIT_PORTS-1:0] commit_valid;
  logic [RCNT_W-1:0]          retire_cnt;

  assign usage_ptr  = tail - head;
  assign full       = (tail[ID_W-1:0] == head[ID_W-1:0]) && (tail[ID_W] != head[ID_W]);
  assign empty      = (tail == head);
  assign issue_fire = bus.issue_req_i && !full;

  cva6_sb_commit_sel #(
    .NR_ENTRIES      (NR_ENTRIES),
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS)
  ) u_commit_sel (
    .valid        (valid),
    .done         (done),
    .head         (head[ID_W-1:0]),
    .ack          (bus.commit_ack_i),
    .commit_valid (commit_valid),
    .commit_id    (bus.commit_id_o),
    .retire_cnt   (retire_cnt)
  );

  // Next ring state; the tail slot is never valid when issuing, so the three updates cannot collide.
  always_comb begin
    valid_next = valid;
    done_next  = done;
    done_next[bus.wb_id_i] = done[bus.wb_id_i] | (bus.wb_valid_i & valid[bus.wb_id_i]);
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      valid_next[head[ID_W-1:0] + ID_W'(k)] =
        valid_next[head[ID_W-1:0] + ID_W'(k)] & ~(RCNT_W'(k) < retire_cnt);
    end
    valid_next[tail[ID_W-1:0]] = valid_next[tail[ID_W-1:0]] | issue_fire;
    done_next[tail[ID_W-1:0]]  = done_next[tail[ID_W-1:0]] & ~issue_fire;
    head_next = head + PTR_W'(retire_cnt);
    tail_next = tail + PTR_W'(issue_fire);
  end

  // Ring state registers; flush behaves like reset for everything but the stall counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else if (bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      valid <= valid_next;
      done  <= done_next;
    end
  end

  assign bus.issue_gnt_o    = !full;
  assign bus.issue_id_o     = tail[ID_W-1:0];
  assign bus.commit_valid_o = commit_valid;
  assign bus.usage_o        = CNT_W'(usage_ptr);
  assign bus.empty_o        = empty;
  assign bus.full_o         = full;

`ifdef CVA6_SB_ID_RING_PERF_EN
  logic [31:0] perf_cnt;

  // Saturating count of issue requests refused because the ring is full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt <= 32'h0;
    end else if (!bus.flush_i && bus.issue_req_i && full && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end else begin
      perf_cnt <= perf_cnt;
    end
  end

  assign bus.perf_stall_cnt_o = perf_cnt;
`else
  assign bus.perf_stall_cnt_o = 32'h0;
`endif

endmodule
